// File: rtl/tone_scheduler_if.sv
// Key/control inputs and tone-generator outputs of tone_scheduler.
interface tone_scheduler_if;
  logic [12:0] keys;
  logic        play;
  logic        stop;
  logic [15:0] divider;
  logic        tone_en;
  logic [3:0]  note;
  logic        playing;

  modport master (output keys, play, stop, input divider, tone_en, note, playing);
  modport slave  (input keys, play, stop, output divider, tone_en, note, playing);
endinterface

// File: rtl/tone_scheduler.sv
// Arbitrates 13 debounced keys and an optional melody player onto one tone generator.
// The melody player (ROM, step counter, PLAY/GAP) exists only when TONE_SCHED_MELODY_EN is defined.
module tone_scheduler #(
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_DIV   = 250000,
  parameter int STEP_TICKS = 25
) (
  input  logic            clk,
  input  logic            reset,
  tone_scheduler_if.slave bus
);
  localparam int         NUM_KEYS = 13;
  localparam int         CNT_W    = $clog2(TICK_DIV);
  localparam logic [3:0] REST     = 4'd15;

  function automatic int note_hz(input int n);
    case (n)
      0: return 440;  1: return 466;  2: return 493;  3: return 523;
      4: return 554;  5: return 587;  6: return 622;  7: return 659;
      8: return 698;  9: return 739; 10: return 783; 11: return 830;
      default: return 880;
    endcase
  endfunction

  logic [15:0] div_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_div
    if (g < NUM_KEYS) begin : g_note
      localparam int DIV = CLK_HZ / (2 * note_hz(g));
      assign div_tab[g] = 16'(DIV);
    end else begin : g_rest
      assign div_tab[g] = '0;
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick, restart;
  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] samp_q, samp_d, deb_q, deb_d;

  always_comb begin
    sync1_d = bus.keys;
    sync2_d = sync1_q;
    cnt_d   = (tick || restart) ? '0 : cnt_q + CNT_W'(1);
    samp_d  = tick ? sync2_q : samp_q;
    // a bit only moves when two consecutive tick samples agree
    deb_d   = tick ? ((sync2_q & samp_q) | (deb_q & (sync2_q ^ samp_q))) : deb_q;
  end

  logic       any_key;
  logic [3:0] win;
  assign any_key = |deb_q;
  always_comb begin
    win = REST;
    for (int i = 0; i < NUM_KEYS; i++) if (deb_q[i]) win = 4'(i);
  end

`ifdef TONE_SCHED_MELODY_EN
  typedef enum logic [1:0] {IDLE, KEY, PLAY, GAP} state_e;
  localparam int         TC_W = $clog2(STEP_TICKS);
  localparam logic [3:0] ROM [16] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12,
                                       4'd12, 4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};
  logic [3:0]      step_q, step_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
`else
  typedef enum logic {IDLE, KEY} state_e;
  logic unused_ctrl;
  assign unused_ctrl = bus.play ^ bus.stop;
`endif

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
`ifdef TONE_SCHED_MELODY_EN
    step_d  = step_q;
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_key) state_d = KEY;
`ifdef TONE_SCHED_MELODY_EN
        else if (bus.play) begin
          // melody steps are timed from the play pulse, so the tick phase restarts here
          state_d = PLAY;
          step_d  = '0;
          tcnt_d  = '0;
          restart = 1'b1;
        end
`endif
      end
      KEY: if (!any_key) state_d = IDLE;
`ifdef TONE_SCHED_MELODY_EN
      PLAY, GAP: begin
        if (any_key || bus.stop) begin
          state_d = any_key ? KEY : IDLE;
          step_d  = '0;
          tcnt_d  = '0;
        end else if (tick) begin
          if (state_q == PLAY) begin
            if (tcnt_q == TC_W'(STEP_TICKS - 2)) begin
              state_d = GAP;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + TC_W'(1);
            end
          end else if (step_q == 4'd15) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            state_d = PLAY;
            step_d  = step_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  logic [15:0] divider_q, divider_d;
  logic        tone_en_q, tone_en_d, playing_q, playing_d;
  logic [3:0]  note_q, note_d;

  // outputs come from the next state so they land on the same edge as the transition
  always_comb begin
    note_d    = REST;
    playing_d = 1'b0;
    case (state_d)
      KEY: note_d = win;
`ifdef TONE_SCHED_MELODY_EN
      PLAY: begin
        note_d    = ROM[step_d];
        playing_d = 1'b1;
      end
      GAP: playing_d = 1'b1;
`endif
      default: ;
    endcase
    tone_en_d = (note_d < 4'(NUM_KEYS));
    divider_d = tone_en_d ? div_tab[note_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      deb_q     <= '0;
      state_q   <= IDLE;
      divider_q <= '0;
      tone_en_q <= 1'b0;
      note_q    <= REST;
      playing_q <= 1'b0;
`ifdef TONE_SCHED_MELODY_EN
      step_q    <= '0;
      tcnt_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      samp_q    <= samp_d;
      deb_q     <= deb_d;
      state_q   <= state_d;
      divider_q <= divider_d;
      tone_en_q <= tone_en_d;
      note_q    <= note_d;
      playing_q <= playing_d;
`ifdef TONE_SCHED_MELODY_EN
      step_q    <= step_d;
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign bus.divider = divider_q;
  assign bus.tone_en = tone_en_q;
  assign bus.note    = note_q;
  assign bus.playing = playing_q;
endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed key/melody scenarios plus random key traffic vs a reference model.
module tb_tone_scheduler;
  localparam int CLK_HZ = 25000000;
  localparam int TD     = 4;
  localparam int ST     = 3;
  localparam int BOUND  = 2 * TD + 3;
  localparam int RN     = 800;

  logic clk = 1'b0;
  logic reset = 1'b1;
  tone_scheduler_if bus ();
  tone_scheduler #(.CLK_HZ(CLK_HZ), .TICK_DIV(TD), .STEP_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int hz  [13] = '{440, 466, 493, 523, 554, 587, 622, 659, 698, 739, 783, 830, 880};
  int rom [16] = '{0, 2, 4, 5, 7, 9, 11, 12, 12, 11, 9, 7, 5, 4, 2, 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_div(input int n);
    return (n < 13) ? CLK_HZ / (2 * hz[n]) : 0;
  endfunction

  function automatic int top_key(input logic [12:0] k);
    int w = 15;
    for (int b = 0; b < 13; b++) if (k[b]) w = b;
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk_out(input string tag, input int note, input int ply);
    chk({tag, ".note"}, int'(bus.note), note);
    chk({tag, ".div"}, int'(bus.divider), exp_div(note));
    chk({tag, ".en"}, int'(bus.tone_en), (note < 13) ? 1 : 0);
    chk({tag, ".playing"}, int'(bus.playing), ply);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] raw_h [RN + 1];
    logic [12:0] m_deb, m_samp, syn, cur;
    int seen, seg, exp_note;

    bus.keys = '0; bus.play = 1'b0; bus.stop = 1'b0;

    // reset held with every key down
    reset = 1'b1; bus.keys = 13'h1FFF;
    for (int i = 0; i < 3; i++) begin cyc(); chk_out("reset", 15, 0); end
    reset = 1'b0; bus.keys = '0;
    cyc(); chk_out("reset_rel", 15, 0);

    // single key
    bus.keys = 13'h0001; hold(BOUND);
    chk_out("key0", 0, 0);
    chk("key0.div_const", int'(bus.divider), 28409);
    bus.keys = '0; hold(BOUND);
    chk_out("key0_rel", 15, 0);

    // fixed priority
    bus.keys = 13'h1008; hold(BOUND);
    chk_out("prio12", 12, 0);
    chk("prio12.div_const", int'(bus.divider), 14204);
    bus.keys = 13'h0008; hold(BOUND);
    chk_out("prio3", 3, 0);
    chk("prio3.div_const", int'(bus.divider), 23900);
    bus.keys = '0; hold(BOUND);

    // one-cycle glitch
    bus.keys = 13'h0020; cyc(); bus.keys = '0;
    seen = 0;
    for (int i = 0; i < 3 * TD; i++) begin cyc(); if (bus.tone_en) seen = 1; end
    chk("glitch.en", seen, 0);

`ifdef TONE_SCHED_MELODY_EN
    // full melody; a second play mid-way must be ignored
    bus.play = 1'b1; cyc(); bus.play = 1'b0;
    chk_out("mel_c0", rom[0], 1);
    chk("mel_c0.div_const", int'(bus.divider), 28409);
    for (int c = 1; c <= 16 * ST * TD; c++) begin
      bus.play = (c == 20);
      cyc();
      if (c == 16 * ST * TD) chk_out("mel_end", 15, 0);
      else chk_out("mel", ((c % (ST * TD)) < (ST - 1) * TD) ? rom[c / (ST * TD)] : 15, 1);
      if (c == ST * TD) chk("step1.div_const", int'(bus.divider), 25354);
    end
    bus.play = 1'b0;

    // key + stop together at step 4
    bus.play = 1'b1; cyc(); bus.play = 1'b0;
    hold(4 * ST * TD);
    chk_out("step4", rom[4], 1);
    bus.keys = 13'h0200; bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    chk("stop.playing", int'(bus.playing), 0);
    hold(BOUND);
    chk_out("stopkey", 9, 0);
    chk("stopkey.div_const", int'(bus.divider), 16914);
    bus.keys = '0; hold(BOUND);

    // key alone aborts the melody
    bus.play = 1'b1; cyc(); bus.play = 1'b0;
    hold(10);
    bus.keys = 13'h0002; hold(BOUND);
    chk_out("abort", 1, 0);
    bus.keys = '0; hold(BOUND);

    // reset mid-melody
    bus.play = 1'b1; cyc(); bus.play = 1'b0;
    hold(30);
    reset = 1'b1; cyc(); chk_out("mreset", 15, 0);
    reset = 1'b0;
    for (int i = 0; i < 2 * ST * TD; i++) begin cyc(); chk_out("mreset_after", 15, 0); end
`else
    bus.play = 1'b1; cyc(); bus.play = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin cyc(); chk_out("noplay", 15, 0); end
`endif

    // random key traffic from a fresh reset against the model
    reset = 1'b1; bus.keys = '0; hold(2); reset = 1'b0;
    m_deb = '0; m_samp = '0; seg = 0; cur = '0;
    for (int k = 1; k <= RN; k++) begin
      if (seg == 0) begin
        seg = $urandom_range(1, 3 * TD);
        case ($urandom_range(0, 3))
          0: cur = '0;
          1: cur = 13'(1 << $urandom_range(0, 12));
          default: cur = 13'($urandom);
        endcase
      end
      seg--;
      bus.keys = cur;
      raw_h[k] = cur;
      syn = (k >= 3) ? raw_h[k - 2] : '0;
      exp_note = top_key(m_deb);
      if (k % TD == 0) begin
        for (int b = 0; b < 13; b++) if (syn[b] == m_samp[b]) m_deb[b] = syn[b];
        m_samp = syn;
      end
      cyc();
      chk_out("rand", exp_note, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
